event_framer: RTL and testbench
===============================

# event_framer

Test-bench source stage that feeds `spaceinputs`. Accepts a back-pressured stream of 36-bit stub words grouped into events by a `lastin` marker, buffers up to two complete events in ping-pong banks, and replays one event per fixed-length event window. For each window it emits a one-cycle event header with the 3-bit BX number and the stub count, followed by the stub words. Its outputs drive `datain`/`eventin`/`bxin`/`numin` of the spacer directly.

## Interface
- `DATA_W`, 36, stub word width
- `BX_W`, 3, BX counter width (wraps)
- `DEPTH`, 64, max stubs stored per event; must be ≤ `EVENT_LEN`-2
- `NUM_W`, 7, stub-count width; must hold `DEPTH`
- `EVENT_LEN`, 108, clocks per event window
- `clk`  in  1  single clock domain
- `reset`  in  1  asynchronous, active-high; all state cleared on assertion
- `BC0`  in  1  bunch-crossing-zero resync pulse
- `datain`  in  DATA_W  incoming stub word
- `validin`  in  1  `datain` valid
- `lastin`  in  1  with `validin`: word is last of its event
- `readyout`  out  1  block can accept a word this cycle
- `dataout`  out  DATA_W  replayed stub word
- `validout`  out  1  `dataout` valid
- `eventout`  out  1  one-cycle event header strobe
- `bxout`  out  BX_W  BX number, valid with `eventout`
- `numout`  out  NUM_W  stub count of the event, valid with `eventout`

## Operation
- Reset: all outputs 0; window counter `wc`=0; BX counter 0; both banks empty; fill pointer = bank 0; read pointer = bank 0.
- Write side: a word is accepted when `validin && readyout`. It is stored at `count` in the fill bank, and `count` increments. Once `count`=`DEPTH`, further words of the event are accepted but dropped; `count` saturates at `DEPTH`.
- Write side, event close: an accepted word with `lastin`=1 closes the bank. The bank is marked full with its count, and the fill pointer toggles. A `lastin` word that overflows is dropped but still closes the bank.
- `readyout` = the bank under the fill pointer is not full. Bank states are empty, filling, full, and reading.
- Window: `wc` counts 0..`EVENT_LEN`-1 and wraps. On each wrap to 0, BX increments modulo 2^`BX_W`.
- At `wc`=0:
  - Always emit a header: `eventout`=1 with the current BX.
  - If the bank at the read pointer is full: `numout`=its count, and the bank goes to reading.
  - Otherwise: `numout`=0 (empty event).
- Read FSM, IDLE: on a header with count>0, go to READ. On a header with count 0, free the bank (if one was taken) and stay in IDLE.
- Read FSM, READ: emit one stored word per cycle with `validout`=1, in write order, with no gaps, for exactly `numout` cycles. After the last word, free the bank (state empty), toggle the read pointer, and return to IDLE.
- `DEPTH` ≤ `EVENT_LEN`-2 guarantees readout completes before the next header.
- `BC0`=1 sampled: next `wc`=0 and next BX=0, so a header follows on the next window start.
  - Any READ in progress aborts: the bank is freed and the read pointer toggles.
  - The filling bank is untouched.
- Bank freed by the read side and made writable in the same cycle: the write sees it writable on the next cycle.

## Timing
- All outputs registered.
- Header latency: `eventout` is high in the cycle after the edge at which `wc`=0.
- First data word follows the header by one cycle. The last word appears at header + `numout` cycles.
- Write-to-replay: an event closed at or before the edge with `wc`=0 is replayed in that window. Otherwise it is replayed in the next window.
- `readyout` deasserts the cycle after the second bank closes. It reasserts the cycle after a bank is freed.
- Reset may assert mid-event or mid-readout. Everything clears immediately, and no partial event is replayed after reset.

## Structure
- Shared package `tracklet_tb_pkg`: `DATA_W`, `BX_W`, `NUM_W` defaults and the bank-state enum (EMPTY, FILLING, FULL, READING).
- Sub-module `event_buffer_bank`:
  - Simple dual-port RAM, 2×`DEPTH`×`DATA_W`, addressed {bank, index}.
  - One-cycle registered read.
  - Write and read ports are independent.
- Top level holds `wc`/BX counters, write control, bank-state registers, and the read FSM.

## Test plan
- Reset, no input: a header every 108 cycles with `numout`=0; BX sequence 1,2,…,7,0 (1st header BX=0).
- One 5-word event (lastin on word 5) written before `wc`=0 → header `numout`=5, then 5 consecutive `validout` cycles with words in order, then idle.
- 70-word event with `DEPTH`=64 → `numout`=64; first 64 words replayed; words 65–70 absent; `readyout` never drops for overflow alone.
- Three back-to-back 10-word events with no replay yet → `readyout` low after the 2nd closes; high one cycle after the 1st bank finishes replay; 3rd event replayed in window 3.
- `BC0` asserted mid-readout of a 40-word event → readout stops next cycle; next header has BX=0 and carries the already-closed next event; the aborted event is not replayed.
- Async `reset` mid-write → all outputs 0 immediately; the next header has `numout`=0 and BX=0.

Source files
------------

// File: rtl/tracklet_tb_pkg.sv
// tracklet_tb_pkg: shared widths and state types for the tracklet test-bench source stages
package tracklet_tb_pkg;
  localparam int DATA_W    = 36;
  localparam int BX_W      = 3;
  localparam int NUM_W     = 7;
  localparam int DEPTH     = 64;
  localparam int EVENT_LEN = 108;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;
endpackage

// File: rtl/event_buffer_bank.sv
// event_buffer_bank: two-bank simple dual-port stub RAM, address {bank, index}, registered read
// Ports: clk, reset (async, clears read register); i_we/i_waddr/i_wdata write port;
//        i_re/i_raddr read request, o_rdata valid one cycle after i_re.
module event_buffer_bank
  import tracklet_tb_pkg::*;
#(
  parameter int   DATA_W = tracklet_tb_pkg::DATA_W,
  parameter int   DEPTH  = tracklet_tb_pkg::DEPTH,
  localparam int  AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AW:0]       i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW:0]       i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**(AW+1)];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/event_framer.sv
// event_framer: buffers up to two stub events in ping-pong banks and replays one per event window
// Ports: clk, reset (async, active-high), BC0 window/BX resync;
//        datain/validin/lastin/readyout: back-pressured input stub stream, lastin closes an event;
//        eventout/bxout/numout: one-cycle header at each window start;
//        dataout/validout: stub words of the replayed event, starting the cycle after the header.
module event_framer #(
  parameter int DATA_W    = tracklet_tb_pkg::DATA_W,
  parameter int BX_W      = tracklet_tb_pkg::BX_W,
  parameter int DEPTH     = tracklet_tb_pkg::DEPTH,
  parameter int NUM_W     = tracklet_tb_pkg::NUM_W,
  parameter int EVENT_LEN = tracklet_tb_pkg::EVENT_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BC0,
  input  logic [DATA_W-1:0] datain,
  input  logic              validin,
  input  logic              lastin,
  output logic              readyout,
  output logic [DATA_W-1:0] dataout,
  output logic              validout,
  output logic              eventout,
  output logic [BX_W-1:0]   bxout,
  output logic [NUM_W-1:0]  numout
);
  import tracklet_tb_pkg::*;
  localparam int AW   = $clog2(DEPTH);
  localparam int WC_W = $clog2(EVENT_LEN);
  logic [WC_W-1:0]  r_wc;
  logic [BX_W-1:0]  r_bx;
  bank_state_t      r_bank [2];
  bank_state_t      w_bank_nxt [2];
  logic [NUM_W-1:0] r_bcnt [2];
  logic             r_wp, r_rp, w_wp_nxt, w_rp_nxt;
  logic [NUM_W-1:0] r_wcnt, w_cnt_inc;
  rd_state_t        r_rs, w_rs_nxt;
  logic [NUM_W-1:0] r_ridx, r_rnum, w_rp_cnt;
  logic             w_acc, w_close, w_store, w_hdr, w_close_rp, w_take, w_rd, w_free;
  assign w_acc      = validin && readyout;
  assign w_close    = w_acc && lastin;
  assign w_store    = w_acc && (r_wcnt < NUM_W'(DEPTH));
  assign w_cnt_inc  = w_store ? r_wcnt + 1'b1 : r_wcnt;
  assign w_hdr      = r_wc == '0;
  // an event closing on the header edge into the read bank is replayed in this same window
  assign w_close_rp = w_close && (r_wp == r_rp);
  assign w_rp_cnt   = w_close_rp ? w_cnt_inc : r_bcnt[r_rp];
  assign w_take     = w_hdr && (r_rs == RD_IDLE) && (r_bank[r_rp] == FULL || w_close_rp);
  assign w_wp_nxt   = r_wp ^ w_close;
  assign w_rp_nxt   = r_rp ^ w_free;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_rs <= RD_IDLE;
    else r_rs <= w_rs_nxt;
  always_comb
    w_rs_nxt = (r_rs == RD_IDLE) ? (w_take ? RD_READ : RD_IDLE) : (w_free ? RD_IDLE : RD_READ);
  // BC0 aborts a readout in progress: no further words, bank released
  always_comb begin
    w_rd   = (r_rs == RD_READ) && !BC0;
    w_free = (r_rs == RD_READ) && (BC0 || r_ridx == r_rnum - 1'b1);
  end
  // read-side updates come last so a bank taken on its closing edge ends up READING
  always_comb begin
    w_bank_nxt = r_bank;
    if (w_acc && r_bank[r_wp] == EMPTY) w_bank_nxt[r_wp] = FILLING;
    if (w_close) w_bank_nxt[r_wp] = FULL;
    if (w_take) w_bank_nxt[r_rp] = READING;
    if (w_free) w_bank_nxt[r_rp] = EMPTY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wc     <= '0;
      r_bx     <= '0;
      r_bank   <= '{EMPTY, EMPTY};
      r_bcnt   <= '{default: '0};
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_wcnt   <= '0;
      r_ridx   <= '0;
      r_rnum   <= '0;
      readyout <= 1'b0;
      validout <= 1'b0;
      eventout <= 1'b0;
      bxout    <= '0;
      numout   <= '0;
    end else begin
      r_wc     <= (BC0 || r_wc == WC_W'(EVENT_LEN - 1)) ? '0 : r_wc + 1'b1;
      r_bx     <= BC0 ? '0 : (r_wc == WC_W'(EVENT_LEN - 1)) ? r_bx + 1'b1 : r_bx;
      r_bank   <= w_bank_nxt;
      r_wp     <= w_wp_nxt;
      r_rp     <= w_rp_nxt;
      r_wcnt   <= w_close ? '0 : w_cnt_inc;
      if (w_close) r_bcnt[r_wp] <= w_cnt_inc;
      r_ridx   <= w_take ? '0 : w_rd ? r_ridx + 1'b1 : r_ridx;
      if (w_take) r_rnum <= w_rp_cnt;
      readyout <= w_bank_nxt[w_wp_nxt] == EMPTY || w_bank_nxt[w_wp_nxt] == FILLING;
      validout <= w_rd;
      eventout <= w_hdr;
      bxout    <= w_hdr ? r_bx : '0;
      numout   <= w_take ? w_rp_cnt : '0;
    end
  event_buffer_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_store),
    .i_waddr({r_wp, r_wcnt[AW-1:0]}),
    .i_wdata(datain),
    .i_re   (w_rd),
    .i_raddr({r_rp, r_ridx[AW-1:0]}),
    .o_rdata(dataout)
  );
endmodule

// File: tb/tb_event_framer.sv
// tb_event_framer: randomized stimulus against an event-queue reference model of event_framer
module tb_event_framer;
  localparam int DATA_W = 36, BX_W = 3, NUM_W = 7, DEPTH = 64, EVENT_LEN = 108;
  logic clk = 1'b0, reset, BC0, validin, lastin;
  logic [DATA_W-1:0] datain, dataout;
  logic readyout, validout, eventout;
  logic [BX_W-1:0] bxout;
  logic [NUM_W-1:0] numout;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  event_framer #(.DATA_W(DATA_W), .BX_W(BX_W), .DEPTH(DEPTH), .NUM_W(NUM_W), .EVENT_LEN(EVENT_LEN)) dut (
    .clk(clk), .reset(reset), .BC0(BC0), .datain(datain), .validin(validin), .lastin(lastin),
    .readyout(readyout), .dataout(dataout), .validout(validout), .eventout(eventout),
    .bxout(bxout), .numout(numout)
  );
  int m_wc, m_bx;
  bit m_ready, m_reading, m_acc;
  logic [DATA_W-1:0] m_cur[$], m_cw[$], m_rd[$];
  int m_cn[$];
  bit e_ev, e_val, e_rdy;
  int e_bx, e_num;
  logic [DATA_W-1:0] e_data;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    m_wc = 0; m_bx = 0; m_ready = 0; m_reading = 0; m_acc = 0;
    m_cur.delete(); m_cw.delete(); m_rd.delete(); m_cn.delete();
    e_ev = 0; e_val = 0; e_rdy = 0; e_bx = 0; e_num = 0; e_data = '0;
  endtask
  // closed events wait in FIFO order; a bank is held from close until its readout ends
  task automatic model_step();
    m_acc = validin && m_ready;
    if (m_acc) begin
      if (m_cur.size() < DEPTH) m_cur.push_back(datain);
      if (lastin) begin
        m_cn.push_back(m_cur.size());
        foreach (m_cur[i]) m_cw.push_back(m_cur[i]);
        m_cur.delete();
      end
    end
    e_ev = (m_wc == 0); e_bx = m_bx; e_num = 0; e_val = 0;
    if (m_reading) begin
      if (BC0) begin m_rd.delete(); m_reading = 0; end
      else begin e_val = 1; e_data = m_rd.pop_front(); m_reading = m_rd.size() != 0; end
    end else if (e_ev && m_cn.size() != 0) begin
      e_num = m_cn.pop_front();
      for (int i = 0; i < e_num; i++) m_rd.push_back(m_cw.pop_front());
      m_reading = 1;
    end
    m_ready = (m_cn.size() + (m_reading ? 1 : 0)) < 2;
    e_rdy = m_ready;
    if (BC0) begin m_wc = 0; m_bx = 0; end
    else if (m_wc == EVENT_LEN - 1) begin m_wc = 0; m_bx = (m_bx + 1) % (1 << BX_W); end
    else m_wc++;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("eventout", 64'(eventout), 64'(e_ev));
    chk("validout", 64'(validout), 64'(e_val));
    chk("readyout", 64'(readyout), 64'(e_rdy));
    if (e_ev) begin
      chk("bxout", 64'(bxout), 64'(e_bx));
      chk("numout", 64'(numout), 64'(e_num));
    end
    if (e_val) chk("dataout", 64'(dataout), 64'(e_data));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_eventout"}, 64'(eventout), 64'(0));
    chk({tag, "_validout"}, 64'(validout), 64'(0));
    chk({tag, "_readyout"}, 64'(readyout), 64'(0));
    chk({tag, "_bxout"}, 64'(bxout), 64'(0));
    chk({tag, "_numout"}, 64'(numout), 64'(0));
    chk({tag, "_dataout"}, 64'(dataout), 64'(0));
  endtask
  task automatic idle(input int n);
    validin = 0; lastin = 0; BC0 = 0;
    repeat (n) tick();
  endtask
  task automatic wait_wc(input int k);
    int g = 0;
    validin = 0; lastin = 0;
    while (m_wc != k && g < 2 * EVENT_LEN) begin tick(); g++; end
    if (m_wc != k) chk("wc_wait", 64'(m_wc), 64'(k));
  endtask
  task automatic send_event(input int n, input int pvalid, input int pbc0, input bit last);
    int i = 0, g = 0;
    bit fresh = 1;
    while (i < n && g < 3000) begin
      if (fresh) datain = DATA_W'({$urandom(), $urandom()});
      validin = $urandom_range(99, 0) < pvalid;
      lastin = last && (i == n - 1);
      BC0 = $urandom_range(999, 0) < pbc0;
      tick(); g++;
      fresh = m_acc;
      if (m_acc) i++;
    end
    if (i < n) chk("send_timeout", 64'(i), 64'(n));
    validin = 0; lastin = 0; BC0 = 0;
  endtask
  task automatic wait_rd_left(input int left);
    int g = 0;
    while (!(m_reading && m_rd.size() == left) && g < 3 * EVENT_LEN) begin tick(); g++; end
    if (g >= 3 * EVENT_LEN) chk("rd_wait_timeout", 64'(m_rd.size()), 64'(left));
  endtask
  initial begin
    reset = 1; BC0 = 0; validin = 0; lastin = 0; datain = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 0;
    idle(9 * EVENT_LEN + 2);
    wait_wc(30);
    send_event(5, 100, 0, 1);
    idle(EVENT_LEN + 10);
    send_event(70, 100, 0, 1);
    idle(2 * EVENT_LEN);
    wait_wc(1);
    for (int e = 0; e < 3; e++) send_event(10, 100, 0, 1);
    idle(4 * EVENT_LEN);
    wait_wc(1);
    send_event(40, 100, 0, 1);
    send_event(10, 100, 0, 1);
    wait_rd_left(25);
    BC0 = 1;
    tick();
    BC0 = 0;
    idle(2 * EVENT_LEN);
    for (int e = 0; e < 25; e++) begin
      send_event($urandom_range(80, 1), $urandom_range(100, 50), (e % 5 == 4) ? 4 : 0, 1);
      idle($urandom_range(150, 0));
    end
    idle(3 * EVENT_LEN);
    wait_wc(20);
    send_event(15, 100, 0, 0);
    validin = 1; lastin = 0; datain = DATA_W'({$urandom(), $urandom()});
    #2 reset = 1;
    #1 chk_zero("async_reset");
    model_reset();
    validin = 0;
    @(negedge clk);
    reset = 0;
    idle(EVENT_LEN + 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
